// File: rtl/pinwheel_pkg.sv
// Shared constants and types for the pinwheel console UART block.
package pinwheel_pkg;

    // Upper address nibble that selects the console on the core data bus.
    localparam logic [3:0] CONSOLE_TAG = 4'hF;

    // Register indices, taken from address bits [3:2].
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_TICKS   = 2'd3;

    // Serializer states.
    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_e;

    // STATUS word layout: [0] full, [1] empty, [2] busy, [3] overflow, [11:8] count.
    function automatic logic [31:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       overflow,
        input logic [3:0] count
    );
        return {20'd0, count, 4'd0, overflow, busy, empty, full};
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Small synchronous FIFO feeding the serializer; a push while full is accepted
// only when a pop happens on the same edge.
module console_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   srst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally (depth is a power of two).
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clock) begin
        if (do_push && !srst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pinwheel_console.sv
// Memory-mapped console: TX FIFO, 8N1 serializer with programmable bit time,
// status/divisor registers and a free-running cycle counter.
module pinwheel_console
    import pinwheel_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic        clock,
    input  logic        tock_reset_in,
    input  logic [31:0] tock_bus_addr,
    input  logic [31:0] tock_bus_wdata,
    input  logic [3:0]  tock_bus_wmask,
    input  logic        tock_bus_wren,
    output logic [31:0] sig_bus_rdata,
    output logic        sig_tx,
    output logic        sig_tx_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic       sel;
    logic [1:0] idx;
    logic       wr_acc;
    logic       push_tx;

    // FIFO interface
    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Register file
    logic [15:0] div_q, div_d;
    logic [31:0] ticks_q, ticks_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rdata_q, rdata_d;

    // Serializer
    ser_state_e  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        baud_done;

    logic unused_bits;
    assign unused_bits = ^{tock_bus_addr[27:4], tock_bus_addr[1:0], tock_bus_wdata[31:16]};

    assign sel     = (tock_bus_addr[31:28] == CONSOLE_TAG);
    assign idx     = tock_bus_addr[3:2];
    assign wr_acc  = sel && tock_bus_wren && (tock_bus_wmask != 4'd0);
    assign push_tx = wr_acc && (idx == REG_TXDATA);

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .srst      (tock_reset_in),
        .push      (push_tx),
        .push_data (tock_bus_wdata[7:0]),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Register writes, sticky overflow, cycle counter and registered read mux.
    always_comb begin
        div_d   = div_q;
        ovf_d   = ovf_q;
        ticks_d = ticks_q + 32'd1;
        rdata_d = 32'd0;
        if (wr_acc) begin
            ticks_d = 32'd0;
        end
        if (wr_acc && idx == REG_DIVISOR) begin
            div_d = tock_bus_wdata[15:0];
        end
        if (push_tx && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
        if (wr_acc && idx == REG_STATUS && tock_bus_wdata[3]) begin
            ovf_d = 1'b0;
        end
        if (sel && !tock_bus_wren) begin
            case (idx)
                REG_STATUS:  rdata_d = pack_status(fifo_full, fifo_empty, busy_q, ovf_q, 4'(fifo_count));
                REG_DIVISOR: rdata_d = {16'd0, div_q};
                // The counter value returned is the one it takes on the capturing edge.
                REG_TICKS:   rdata_d = ticks_d;
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    // Serializer next state: each bit holds for DIVISOR+1 cycles, divisor sampled at bit start.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        baud_done = (baud_q == 16'd0);
        case (state_q)
            SER_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = div_q;
                    state_d  = SER_START;
                    tx_d     = 1'b0;
                end
            end
            SER_START: begin
                if (baud_done) begin
                    state_d   = SER_DATA;
                    baud_d    = div_q;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            SER_DATA: begin
                if (baud_done) begin
                    baud_d = div_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = SER_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            SER_STOP: begin
                if (baud_done) begin
                    state_d = SER_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = SER_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != SER_IDLE);
    end

    // State registers; reset aborts any frame and ignores coincident bus writes.
    always_ff @(posedge clock) begin
        if (tock_reset_in) begin
            state_q   <= SER_IDLE;
            baud_q    <= 16'd0;
            shift_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            div_q     <= 16'(DEFAULT_DIV);
            ticks_q   <= 32'd0;
            ovf_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            div_q     <= div_d;
            ticks_q   <= ticks_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
        end
    end

    assign sig_tx        = tx_q;
    assign sig_tx_busy   = busy_q;
    assign sig_bus_rdata = rdata_q;

endmodule

// File: doc/pinwheel_console.md
PINWHEEL_CONSOLE -- requirements
Module: pinwheel_console

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries; must be a power of two and at least 2.
REQ-002 SHALL have parameter DEFAULT_DIV, default 3, reset value of DIVISOR.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port tock_reset_in, input, 1, synchronous active-high reset.
REQ-005 SHALL have port tock_bus_addr, input, 32, byte address from the core data bus.
REQ-006 SHALL have port tock_bus_wdata, input, 32, write data.
REQ-007 SHALL have port tock_bus_wmask, input, 4, byte-lane mask.
REQ-008 SHALL have port tock_bus_wren, input, 1, write strobe.
REQ-009 SHALL have port sig_bus_rdata, output, 32, registered read data.
REQ-010 SHALL have port sig_tx, output, 1, serial line, idle high.
REQ-011 SHALL have port sig_tx_busy, output, 1, high while the serializer is not IDLE.

Function
REQ-012 SHALL select itself when tock_bus_addr[31:28]==4'hF; the register index is tock_bus_addr[3:2]; no other address bits are decoded.
REQ-013 SHALL accept a write only when selected, tock_bus_wren=1 and tock_bus_wmask!=0.
REQ-014 Register 0 TXDATA, write: SHALL push wdata[7:0] into the FIFO; reads return 0.
REQ-015 Register 1 STATUS, read: [0]=full, [1]=empty, [2]=busy, [3]=overflow, [7:4]=0, [11:8]=FIFO count, rest 0; a write with wdata[3]=1 SHALL clear overflow.
REQ-016 Register 2 DIVISOR, RW, 16 bits, zero-extended on read.
REQ-017 Register 3 TICKS, read-only free-running 32-bit cycle counter that wraps at 2^32; any accepted write SHALL clear it to 0 on that edge.
REQ-018 Read latency SHALL be one cycle: sig_bus_rdata after edge N reflects the selected register at edge N when wren=0; otherwise it is 0.
REQ-019 A push when full without a same-cycle pop SHALL drop the byte and set overflow (sticky); a push when full with a same-cycle pop SHALL be accepted and the count is unchanged.
REQ-020 Serializer FSM SHALL have states IDLE, START, DATA, STOP: IDLE->START pops the FIFO head when it is non-empty; START drives 0; DATA drives 8 bits LSB first; STOP drives 1; STOP->IDLE.
REQ-021 Each START, DATA and STOP bit SHALL last exactly DIVISOR+1 cycles; the baud counter loads DIVISOR at each bit start and counts down to 0.
REQ-022 A DIVISOR write mid-frame SHALL take effect at the next bit boundary; the current bit is unaffected.
REQ-023 Back-to-back bytes SHALL have exactly one IDLE cycle (sig_tx=1) between the end of STOP and the next START.
REQ-024 DIVISOR=0 SHALL give one cycle per bit; there is no divide-by-zero case.
REQ-025 sig_tx and sig_tx_busy SHALL be registered outputs.

Reset
REQ-026 While tock_reset_in=1 at an edge, the block SHALL take these values: state IDLE, sig_tx=1, sig_tx_busy=0, FIFO empty (count 0), overflow 0, DIVISOR=DEFAULT_DIV, TICKS=0, sig_bus_rdata=0.
REQ-027 Reset mid-frame SHALL abort the frame, return sig_tx high on the next cycle, and discard FIFO contents.
REQ-028 Bus writes coincident with reset SHALL be ignored.

Structure
REQ-029 The shared package pinwheel_pkg SHALL hold the console tag constant 4'hF, the register index constants and the serializer state enum.
REQ-030 The FIFO SHALL be the sub-module console_fifo (push/pop/full/empty/count, synchronous reset); the FSM and register file stay in pinwheel_console.

Verification
REQ-031 Reset, then write 0x55 to 0xF0000000 with DIVISOR=3 -> sig_tx goes low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, high for 4 cycles; busy is high throughout.
REQ-032 Write 10 bytes back-to-back with the serializer stalled (DIVISOR=0xFFFF) -> STATUS reads count=8, full=1, overflow=1; writing STATUS with 0x8 reads overflow=0.
REQ-033 Write DIVISOR=1 during bit 3 of a frame at DIVISOR=5 -> bit 3 lasts 6 cycles and bit 4 onward lasts 2 cycles.
REQ-034 Read TICKS at two edges 10 cycles apart -> the values differ by 10; a write to TICKS makes the next read return 1.
REQ-035 Assert reset mid-DATA with 3 bytes queued -> sig_tx=1 on the next cycle, STATUS=0x002, and no further frame is sent.
REQ-036 Access 0x80000004 or wmask=0 -> no state change and sig_bus_rdata=0.
